nibble_adder_bist: RTL and testbench

Self-test initiator for the nibble-adder tile. It drives the adder's 8-bit operand pins, sweeping all 256 nibble pairs in order. For each pair it samples the adder's 8-bit sum and compares it against an internal reference model. It reports pass/fail, a mismatch count and the first failing vector, and sits on the tester/harness side of the adder's ui_in/uo_out interface.

---
 rtl/nibble_bist_pkg.sv | 30 +++
 rtl/nibble_sum_ref.sv | 11 +
 rtl/nibble_adder_bist.sv | 135 +++++++++++++
 tb/tb_nibble_adder_bist.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_bist_pkg.sv
// Shared types, widths and the reference sum for the nibble-adder self-test.
package nibble_bist_pkg;

  localparam int unsigned OP_W  = 8;
  localparam int unsigned SUM_W = 8;
  localparam int unsigned ERR_W = 9;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned NIB_W = 4;

  localparam logic [OP_W-1:0] LAST_OP = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CHECK,
    DONE
  } state_t;

  // Snapshot of the first vector that disagreed with the reference
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [SUM_W-1:0] sum;
  } fail_rec_t;

  // A in [3:0], B in [7:4]; both zero-extended so no carry is lost
  function automatic logic [SUM_W-1:0] expected_sum(input logic [OP_W-1:0] op);
    return SUM_W'(op[NIB_W-1:0]) + SUM_W'(op[OP_W-1:NIB_W]);
  endfunction

endpackage

// File: rtl/nibble_sum_ref.sv
// Combinational reference adder used by the checker to predict each sum.
module nibble_sum_ref
  import nibble_bist_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  output logic [SUM_W-1:0] sum_c
);

  assign sum_c = expected_sum(op);

endmodule

// File: rtl/nibble_adder_bist.sv
// Sweeps all 256 nibble pairs into the adder, checks each returned sum and
// records the mismatch count plus the first failing vector.
module nibble_adder_bist
  import nibble_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [OP_W-1:0]  operand_out,
  input  logic [SUM_W-1:0] sum_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [OP_W-1:0]  first_fail_op,
  output logic [SUM_W-1:0] first_fail_sum
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [OP_W-1:0]  op_d;
  logic [ERR_W-1:0] err_d;
  logic             fv_d;
  logic             done_d;
  logic             busy_d;
  logic             pass_d;
  fail_rec_t        first_fail, first_fail_d;
  logic [SUM_W-1:0] exp_sum_c;
  logic             mismatch_c;

  nibble_sum_ref u_ref (
    .op    (operand_out),
    .sum_c (exp_sum_c)
  );

  assign mismatch_c     = (sum_in != exp_sum_c);
  assign first_fail_op  = first_fail.op;
  assign first_fail_sum = first_fail.sum;

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      operand_out <= '0;
      err_count   <= '0;
      fail_valid  <= 1'b0;
      first_fail  <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      operand_out <= op_d;
      err_count   <= err_d;
      fail_valid  <= fv_d;
      first_fail  <= first_fail_d;
      done        <= done_d;
      busy        <= busy_d;
      pass        <= pass_d;
    end
  end

  // Next-state and next-result logic; abort outranks start while busy
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    op_d         = operand_out;
    err_d        = err_count;
    fv_d         = fail_valid;
    first_fail_d = first_fail;
    done_d       = done;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          op_d         = '0;
          err_d        = '0;
          fv_d         = 1'b0;
          first_fail_d = '0;
          cnt_d        = '0;
          done_d       = 1'b0;
          state_d      = APPLY;
        end
      end

      APPLY: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = CHECK;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      CHECK: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (mismatch_c) begin
            err_d = err_count + ERR_W'(1);
            if (!fail_valid) begin
              fv_d             = 1'b1;
              first_fail_d.op  = operand_out;
              first_fail_d.sum = sum_in;
            end
          end
          if (operand_out == LAST_OP) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            op_d    = operand_out + OP_W'(1);
            state_d = APPLY;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == APPLY) || (state_d == CHECK);
    pass_d = done_d && (err_d == '0);
  end

endmodule

// File: tb/tb_nibble_adder_bist.sv
// Directed bench: drives the BIST against a good, single-fault and stuck-at
// adder, plus abort, restart, slow-settle and mid-sweep reset scenarios.
module tb_nibble_adder_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1, abort1, start3, abort3;
  logic [7:0] op1, op3, sum1, sum3;
  logic       busy1, done1, pass1, fv1;
  logic       busy3, done3, pass3, fv3;
  logic [8:0] err1, err3;
  logic [7:0] ffop1, ffsum1, ffop3, ffsum3;
  int         mode;  // 0 good adder, 1 fault at 8'h37, 2 sum stuck at 0
  int         n_run = 0;
  int         n_fail = 0;
  int         cyc;

  nibble_adder_bist #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .operand_out(op1), .sum_in(sum1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_valid(fv1),
    .first_fail_op(ffop1), .first_fail_sum(ffsum1)
  );

  nibble_adder_bist #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3),
    .operand_out(op3), .sum_in(sum3), .busy(busy3), .done(done3),
    .pass(pass3), .err_count(err3), .fail_valid(fv3),
    .first_fail_op(ffop3), .first_fail_sum(ffsum3)
  );

  function automatic logic [7:0] adder(input logic [7:0] op);
    return {4'b0000, op[3:0]} + {4'b0000, op[7:4]};
  endfunction

  // Adder tile models seen on the far side of the pins
  always_comb begin
    sum1 = adder(op1);
    if (mode == 1 && op1 == 8'h37) sum1 = adder(op1) ^ 8'h01;
    else if (mode == 2) sum1 = 8'h00;
    sum3 = adder(op3);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic kick(input bit sel);
    if (sel) start3 = 1'b1; else start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int limit, output int cycles);
    cycles = 0;
    while (!(sel ? done3 : done1) && cycles < limit) begin
      step(1);
      cycles++;
    end
    check("done_seen", 32'(sel ? done3 : done1), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    mode = 0;
    step(2);
    check("rst_op", 32'(op1), 32'h0);
    check("rst_busy", 32'(busy1), 32'h0);
    check("rst_done", 32'(done1), 32'h0);
    check("rst_pass", 32'(pass1), 32'h0);
    check("rst_err", 32'(err1), 32'h0);
    check("rst_fv", 32'(fv1), 32'h0);
    check("rst_ffop", 32'(ffop1), 32'h0);
    check("rst_ffsum", 32'(ffsum1), 32'h0);
    rst = 1'b0;
    step(1);

    // Good adder, one cycle settle: done at start + 512
    kick(1'b0);
    check("golden_busy", 32'(busy1), 32'd1);
    wait_done(1'b0, 600, cyc);
    check("golden_latency", 32'(cyc), 32'd512);
    check("golden_pass", 32'(pass1), 32'd1);
    check("golden_err", 32'(err1), 32'd0);
    check("golden_fv", 32'(fv1), 32'd0);
    check("golden_busy_end", 32'(busy1), 32'd0);

    // Single fault at 8'h37: 3+7=0x0A, observed 0x0B
    mode = 1;
    kick(1'b0);
    wait_done(1'b0, 600, cyc);
    check("f37_err", 32'(err1), 32'd1);
    check("f37_ffop", 32'(ffop1), 32'h37);
    check("f37_ffsum", 32'(ffsum1), 32'h0B);
    check("f37_fv", 32'(fv1), 32'd1);
    check("f37_pass", 32'(pass1), 32'd0);

    // Stuck at zero: only vector 8'h00 agrees
    mode = 2;
    kick(1'b0);
    wait_done(1'b0, 600, cyc);
    check("stuck_err", 32'(err1), 32'd255);
    check("stuck_ffop", 32'(ffop1), 32'h01);
    check("stuck_ffsum", 32'(ffsum1), 32'h00);
    check("stuck_pass", 32'(pass1), 32'd0);

    // Restart from DONE with a good adder clears results immediately
    mode = 0;
    kick(1'b0);
    check("restart_err", 32'(err1), 32'd0);
    check("restart_done", 32'(done1), 32'd0);
    check("restart_fv", 32'(fv1), 32'd0);
    wait_done(1'b0, 600, cyc);
    check("restart_pass", 32'(pass1), 32'd1);
    check("restart_final_err", 32'(err1), 32'd0);

    // Abort after 100 vectors with a stuck adder; a mid-sweep start is ignored
    mode = 2;
    kick(1'b0);
    step(49);
    start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    check("busy_start_err", 32'(err1), 32'd24);
    check("busy_start_busy", 32'(busy1), 32'd1);
    step(150);
    check("pre_abort_err", 32'(err1), 32'd99);
    abort1 = 1'b1;
    step(1);
    abort1 = 1'b0;
    check("abort_busy", 32'(busy1), 32'd0);
    check("abort_done", 32'(done1), 32'd0);
    check("abort_err", 32'(err1), 32'd99);
    check("abort_fv", 32'(fv1), 32'd1);
    check("abort_ffop", 32'(ffop1), 32'h01);
    abort1 = 1'b1;
    step(3);
    abort1 = 1'b0;
    check("idle_abort_busy", 32'(busy1), 32'd0);
    check("idle_abort_err", 32'(err1), 32'd99);

    // Three-cycle settle: each operand held for four cycles total
    kick(1'b1);
    check("s3_op_0", 32'(op3), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check($sformatf("s3_op_%0d", k), 32'(op3), 32'(k / 4));
    end
    wait_done(1'b1, 1100, cyc);
    check("s3_latency", 32'(cyc + 12), 32'd1024);
    check("s3_pass", 32'(pass3), 32'd1);

    // Reset in the middle of a sweep
    kick(1'b1);
    step(300);
    check("mid_busy", 32'(busy3), 32'd1);
    check("mid_op", 32'(op3), 32'd75);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mrst_op", 32'(op3), 32'd0);
    check("mrst_busy", 32'(busy3), 32'd0);
    check("mrst_done", 32'(done3), 32'd0);
    check("mrst_pass", 32'(pass3), 32'd0);
    check("mrst_err", 32'(err3), 32'd0);
    check("mrst_fv", 32'(fv3), 32'd0);
    step(2);
    check("mrst_stays_idle", 32'(busy3), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
